// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state type and prefetch-queue entry type for the fetch stage.
package fetch_pkg;

    localparam int FETCH_INST_W = 26;
    localparam int FETCH_ADDR_W = 32;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // One fetched word together with the PC it was read from.
    typedef struct packed {
        logic [FETCH_INST_W-1:0] inst;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of fetch_entry_t with push, pop and flush.
// The head entry is held in its own register so it keeps its value once the queue drains.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_next;
    fetch_entry_t     head_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    // Flush wins over everything; popping an empty queue is ignored.
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Next read pointer, next occupancy and the entry that will be at the head after this edge.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        rd_next    = rd_ptr;
        count_next = count;
        head_next  = mem[rd_ptr];
        if (flush) begin
            rd_next    = '0;
            count_next = '0;
        end else begin
            if (do_pop) begin
                rd_next = rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_next = count + 1'b1;
            end else if (do_pop && !do_push) begin
                count_next = count - 1'b1;
            end
            // A word written into the slot that becomes the head bypasses the array.
            head_next = (do_push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
        end
    end

    // Pointers, occupancy and the registered head entry.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_next;
            count  <= count_next;
            if (flush) begin
                wr_ptr <= '0;
            end else if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (count_next != '0) begin
                head <= head_next;
            end
        end
    end

    // Entry storage.
    // NOTE: the array has no reset; occupancy and the head register decide what is visible, so stale words never escape.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, drives the synchronous instruction ROM
// (one-cycle read latency) and buffers returned words in a prefetch queue so decode stalls
// never drop instructions. A redirect flushes the queue and kills the read in flight.
// Optional macro FETCH_PERF_EN adds the perf_fetched / perf_bubble counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                INST_W   = FETCH_INST_W,
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_q,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubble
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tag_pc;
    logic              inflight;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  q_count;
    logic              q_empty;
    logic              q_full;
    fetch_entry_t      push_data;
    fetch_entry_t      head;

    assign imem_addr = pc;

    // The ROM word returning now belongs to the PC tagged on the previous edge.
    assign push      = inflight && !redirect_valid;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign push_data = '{inst: imem_q, pc: tag_pc};

    assign out_valid = !q_empty;
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;

    // FSM next state and the issue decision. BOOT presents RESET_PC to the ROM as a warm-up
    // read that is not tracked; tracked issue starts in RUN, and only while the queue plus
    // the read in flight leave a free slot.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                state_next = RUN;
                issue      = ((q_count + CNT_W'(inflight)) < CNT_W'(DEPTH)) && !redirect_valid;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // PC, in-flight flag and the PC tag of the outstanding ROM read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            tag_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc <= pc + 1'b1;
            end
            if (issue) begin
                tag_pc <= pc;
            end
            inflight <= issue;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    // Credit accounting guarantees a push never lands in a full, non-draining queue.
    assert property (@(posedge clk) disable iff (!rst) !(push && q_full && !pop));

`ifdef FETCH_PERF_EN
    // Delivered-instruction and decode-bubble counters; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_bubble  <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (out_ready && !out_valid) begin
                perf_bubble <= perf_bubble + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A behavioural model tracks the PC stream
// decode should see (consecutive from the last redirect target or RESET_PC) and the words
// the ROM holds; scenario tasks check latency, stalls, redirects, wrap and async reset.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int          INST_W   = 26;
    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_q;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_bubble;
`endif

    int passed = 0;
    int total  = 0;

    // Reference model state, updated at every falling edge.
    logic [31:0] exp_next    = RESET_PC;
    logic [31:0] exp_fetched = '0;
    logic [31:0] exp_bubble  = '0;
    int          pops        = 0;
    int          seq_err     = 0;
    logic [31:0] bad_got_pc  = '0;
    logic [31:0] bad_exp_pc  = '0;

    fetch_unit #(
        .INST_W   (INST_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubble    (perf_bubble)
`endif
    );

    always #5 clk = ~clk;

    // ROM contents: address + 0x100 for low addresses, with high address bits folded in.
    function automatic logic [INST_W-1:0] rom_word(input logic [31:0] a);
        logic [31:0] w;
        w = (a + 32'h100) ^ (a >> 16);
        return w[INST_W-1:0];
    endfunction

    // Synchronous ROM with one-cycle read latency.
    always @(posedge clk) imem_q <= rom_word(imem_addr);

    // Model of the delivered stream: every accepted word must be the next consecutive PC
    // after the latest redirect target (or RESET_PC), carrying that PC's ROM word.
    always @(negedge clk) begin
        if (!rst) begin
            exp_next    = RESET_PC;
            exp_fetched = '0;
            exp_bubble  = '0;
        end else begin
            if (out_ready && !out_valid) exp_bubble = exp_bubble + 32'd1;
            if (redirect_valid) begin
                exp_next = redirect_pc;
            end else if (out_valid && out_ready) begin
                pops++;
                exp_fetched = exp_fetched + 32'd1;
                if (out_pc !== exp_next || out_inst !== rom_word(exp_next)) begin
                    if (seq_err == 0) begin
                        bad_got_pc = out_pc;
                        bad_exp_pc = exp_next;
                    end
                    seq_err++;
                end
                exp_next = exp_next + 32'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, then release just after an edge; the next edge is E0.
    task automatic do_reset(input logic rdy);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = rdy;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", out_pc); else passed++;
        total++; if (out_inst !== '0) $display("FAIL reset_inst: got %h want 0", out_inst); else passed++;
        total++; if (imem_addr !== RESET_PC) $display("FAIL reset_imem_addr: got %h want %h", imem_addr, RESET_PC); else passed++;
    endtask

    task automatic test_boot_stream();
        logic v0, v1;
        int   s, p, bubbles;
        tick();
        do_reset(1'b1);
        s = seq_err; p = pops;
        @(posedge clk); @(negedge clk); v0 = out_valid;   // after E0
        @(posedge clk); @(negedge clk); v1 = out_valid;   // after E1
        @(posedge clk); @(negedge clk);                   // after E2
        total++; if ({v0, v1, out_valid} !== 3'b001) $display("FAIL boot_latency: valid after E0,E1,E2 = %b want 001", {v0, v1, out_valid}); else passed++;
        total++; if (out_pc !== RESET_PC) $display("FAIL boot_first_pc: got %h want %h", out_pc, RESET_PC); else passed++;
        total++; if (out_inst !== rom_word(RESET_PC)) $display("FAIL boot_first_inst: got %h want %h", out_inst, rom_word(RESET_PC)); else passed++;
        bubbles = 0;
        repeat (30) begin
            @(negedge clk);
            if (!out_valid) bubbles++;
        end
        tick();
        total++; if (bubbles !== 0) $display("FAIL boot_throughput: %0d bubbles want 0", bubbles); else passed++;
        total++; if (seq_err - s !== 0) $display("FAIL boot_stream: %0d bad words, first pc %h want %h", seq_err - s, bad_got_pc, bad_exp_pc); else passed++;
        total++; if (pops - p !== 31) $display("FAIL boot_pop_count: got %0d want 31", pops - p); else passed++;
    endtask

    task automatic test_stall();
        int s, p, bubbles, bound_bad;
        do_reset(1'b0);
        s = seq_err; p = pops;
        repeat (12) tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", out_valid); else passed++;
        total++; if (imem_addr !== RESET_PC + 32'(DEPTH)) $display("FAIL stall_imem_addr: got %h want %h", imem_addr, RESET_PC + 32'(DEPTH)); else passed++;
        total++; if (out_pc !== RESET_PC) $display("FAIL stall_head_pc: got %h want %h", out_pc, RESET_PC); else passed++;
        total++; if (pops - p !== 0) $display("FAIL stall_no_pop: got %0d pops want 0", pops - p); else passed++;
        tick();
        out_ready = 1'b1;
        bubbles = 0;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid) bubbles++;
        end
        tick();
        total++; if (bubbles !== 0) $display("FAIL stall_release_bubbles: %0d want 0", bubbles); else passed++;
        bound_bad = 0;
        repeat (200) begin
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (out_valid && ((imem_addr - out_pc) > 32'(DEPTH))) bound_bad++;
            tick();
        end
        out_ready = 1'b1;
        repeat (10) tick();
        total++; if (bound_bad !== 0) $display("FAIL stall_outstanding_bound: %0d cycles over %0d", bound_bad, DEPTH); else passed++;
        total++; if (seq_err - s !== 0) $display("FAIL stall_stream: %0d bad words, first pc %h want %h", seq_err - s, bad_got_pc, bad_exp_pc); else passed++;
        total++; if ((pops - p) < 20) $display("FAIL stall_pop_count: got %0d want >= 20", pops - p); else passed++;
`ifdef FETCH_PERF_EN
        total++; if (perf_fetched !== exp_fetched) $display("FAIL perf_fetched: got %0d want %0d", perf_fetched, exp_fetched); else passed++;
        total++; if (perf_bubble !== exp_bubble) $display("FAIL perf_bubble: got %0d want %0d", perf_bubble, exp_bubble); else passed++;
`endif
    endtask

    task automatic test_redirect();
        logic [31:0] a1;
        logic        v1, v2;
        int          s, p;
        do_reset(1'b0);
        repeat (5) tick();                               // queue holds 3 entries
        s = seq_err; p = pops;
        redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;   // cycle N
        tick();
        redirect_valid = 1'b0;
        @(negedge clk); a1 = imem_addr; v1 = out_valid;   // N+1
        tick();
        @(negedge clk); v2 = out_valid;                   // N+2
        tick();
        @(negedge clk);                                   // N+3
        total++; if (a1 !== 32'h40) $display("FAIL redirect_imem_addr: got %h want 00000040", a1); else passed++;
        total++; if ({v1, v2, out_valid} !== 3'b001) $display("FAIL redirect_latency: valid N+1..N+3 = %b want 001", {v1, v2, out_valid}); else passed++;
        total++; if (out_pc !== 32'h40) $display("FAIL redirect_first_pc: got %h want 00000040", out_pc); else passed++;
        repeat (10) tick();
        total++; if (seq_err - s !== 0) $display("FAIL redirect_stream: %0d bad words, first pc %h want %h", seq_err - s, bad_got_pc, bad_exp_pc); else passed++;
        total++; if (pops - p !== 10) $display("FAIL redirect_pop_count: got %0d want 10", pops - p); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a2;
        logic        v2, v3;
        int          s, bound_bad;
        s = seq_err;
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h40;      // cycle N, queue popping and pushing
        tick();
        redirect_pc = 32'h80;                             // cycle N+1
        tick();
        redirect_valid = 1'b0;
        @(negedge clk); a2 = imem_addr; v2 = out_valid;   // N+2
        tick();
        @(negedge clk); v3 = out_valid;                   // N+3
        tick();
        @(negedge clk);                                   // N+4
        total++; if (a2 !== 32'h80) $display("FAIL b2b_imem_addr: got %h want 00000080", a2); else passed++;
        total++; if ({v2, v3, out_valid} !== 3'b001) $display("FAIL b2b_latency: valid N+2..N+4 = %b want 001", {v2, v3, out_valid}); else passed++;
        total++; if (out_pc !== 32'h80) $display("FAIL b2b_first_pc: got %h want 00000080", out_pc); else passed++;
        tick();
        bound_bad = 0;
        repeat (300) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : 32'($urandom);
            end else begin
                redirect_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid && ((imem_addr - out_pc) > 32'(DEPTH))) bound_bad++;
            tick();
        end
        redirect_valid = 1'b0; out_ready = 1'b1;
        repeat (10) tick();
        total++; if (bound_bad !== 0) $display("FAIL random_outstanding_bound: %0d cycles over %0d", bound_bad, DEPTH); else passed++;
        total++; if (seq_err - s !== 0) $display("FAIL random_stream: %0d bad words, first pc %h want %h", seq_err - s, bad_got_pc, bad_exp_pc); else passed++;
    endtask

    task automatic test_wrap();
        int s;
        s = seq_err;
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;   // cycle N
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        @(negedge clk);                                       // N+3
        total++; if (out_pc !== 32'hFFFF_FFFF) $display("FAIL wrap_last_pc: got %h want ffffffff", out_pc); else passed++;
        total++; if (out_inst !== rom_word(32'hFFFF_FFFF)) $display("FAIL wrap_last_inst: got %h want %h", out_inst, rom_word(32'hFFFF_FFFF)); else passed++;
        tick();
        @(negedge clk);                                       // N+4
        total++; if (out_pc !== 32'h0) $display("FAIL wrap_zero_pc: got %h want 00000000", out_pc); else passed++;
        total++; if (out_inst !== rom_word(32'h0)) $display("FAIL wrap_zero_inst: got %h want %h", out_inst, rom_word(32'h0)); else passed++;
        repeat (6) tick();
        total++; if (seq_err - s !== 0) $display("FAIL wrap_stream: %0d bad words, first pc %h want %h", seq_err - s, bad_got_pc, bad_exp_pc); else passed++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        repeat (5) tick();
`ifdef FETCH_PERF_EN
        total++; if (perf_fetched !== exp_fetched) $display("FAIL perf_fetched_end: got %0d want %0d", perf_fetched, exp_fetched); else passed++;
        total++; if (perf_bubble !== exp_bubble) $display("FAIL perf_bubble_end: got %0d want %0d", perf_bubble, exp_bubble); else passed++;
`endif
        #2 rst = 1'b0;                                        // between edges
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL async_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_pc !== 32'h0) $display("FAIL async_pc: got %h want 0", out_pc); else passed++;
        total++; if (out_inst !== '0) $display("FAIL async_inst: got %h want 0", out_inst); else passed++;
        total++; if (imem_addr !== RESET_PC) $display("FAIL async_imem_addr: got %h want %h", imem_addr, RESET_PC); else passed++;
`ifdef FETCH_PERF_EN
        total++; if ({perf_fetched, perf_bubble} !== 64'h0) $display("FAIL async_perf: got %0d/%0d want 0/0", perf_fetched, perf_bubble); else passed++;
`endif
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_boot_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
